// File: rtl/gactx_dir_reader.sv
// gactx_dir_reader: streams packed 2-bit traceback directions out of the dir
// BRAM and run-length encodes them into (op, len, last) records.
// Ports:
//   clk, rst            - clock, synchronous active-high reset
//   start, clear_done   - launch a tile (IDLE only), return DONE -> IDLE
//   num_tb_steps        - directions to read, latched on start
//   dir_total_count     - valid words in the dir BRAM, latched on start
//   dir_rd_addr         - BRAM read address (data returns one cycle later)
//   dir_data_out        - BRAM read data, NUM_DIR_BLOCK 2-bit lanes
//   out_valid/out_ready - record handshake; out_op/out_len/out_last payload
//   busy, done, overrun - status; overrun = ran out of stored words
module gactx_dir_reader #(
    parameter int unsigned LOG_MAX_TILE_SIZE   = 11,
    parameter int unsigned NUM_DIR_BLOCK       = 32,
    parameter int unsigned DIR_BRAM_ADDR_WIDTH = 14
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           start,
    input  logic [2*LOG_MAX_TILE_SIZE-1:0] num_tb_steps,
    input  logic [DIR_BRAM_ADDR_WIDTH-1:0] dir_total_count,
    output logic [DIR_BRAM_ADDR_WIDTH-1:0] dir_rd_addr,
    input  logic [2*NUM_DIR_BLOCK-1:0]     dir_data_out,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [1:0]                     out_op,
    output logic [2*LOG_MAX_TILE_SIZE-1:0] out_len,
    output logic                           out_last,
    output logic                           busy,
    output logic                           done,
    output logic                           overrun,
    input  logic                           clear_done
);

    localparam int unsigned STEP_W = 2 * LOG_MAX_TILE_SIZE;
    localparam int unsigned WORD_W = 2 * NUM_DIR_BLOCK;
    localparam int unsigned AW     = DIR_BRAM_ADDR_WIDTH;
    localparam int unsigned AW1    = AW + 1;
    localparam int unsigned LANE_W = (NUM_DIR_BLOCK > 1) ? $clog2(NUM_DIR_BLOCK) : 1;
    localparam logic [LANE_W-1:0] LANE_LAST = LANE_W'(NUM_DIR_BLOCK - 1);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_FETCH  = 3'd1;
    localparam logic [2:0] S_WAIT   = 3'd2;
    localparam logic [2:0] S_UNPACK = 3'd3;
    localparam logic [2:0] S_EMIT   = 3'd4;
    localparam logic [2:0] S_DONE   = 3'd5;

    logic [2:0]        state_q,    state_d;
    logic [2:0]        ret_q,      ret_d;
    logic              pend_q,     pend_d;
    logic [STEP_W-1:0] steps_q,    steps_d;
    logic [AW-1:0]     total_q,    total_d;
    logic [AW-1:0]     word_q,     word_d;
    logic [LANE_W-1:0] lane_q,     lane_d;
    logic [STEP_W-1:0] step_q,     step_d;
    logic [1:0]        run_op_q,   run_op_d;
    logic [STEP_W-1:0] run_len_q,  run_len_d;
    logic [WORD_W-1:0] word_buf_q, word_buf_d;

    logic [AW-1:0]     dir_rd_addr_d;
    logic              out_valid_d, out_last_d, busy_d, done_d, overrun_d;
    logic [1:0]        out_op_d;
    logic [STEP_W-1:0] out_len_d;

    logic [WORD_W-1:0] lane_word;
    logic [1:0]        lane_op;
    logic [STEP_W-1:0] step_inc;
    logic [AW1-1:0]    word_inc;
    logic              last_step, lane_end, out_of_words, stop_now, extend;
    logic [2:0]        cont_state;

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            ret_q       <= S_IDLE;
            pend_q      <= 1'b0;
            steps_q     <= '0;
            total_q     <= '0;
            word_q      <= '0;
            lane_q      <= '0;
            step_q      <= '0;
            run_op_q    <= '0;
            run_len_q   <= '0;
            word_buf_q  <= '0;
            dir_rd_addr <= '0;
            out_valid   <= 1'b0;
            out_op      <= '0;
            out_len     <= '0;
            out_last    <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            overrun     <= 1'b0;
        end else begin
            state_q     <= state_d;
            ret_q       <= ret_d;
            pend_q      <= pend_d;
            steps_q     <= steps_d;
            total_q     <= total_d;
            word_q      <= word_d;
            lane_q      <= lane_d;
            step_q      <= step_d;
            run_op_q    <= run_op_d;
            run_len_q   <= run_len_d;
            word_buf_q  <= word_buf_d;
            dir_rd_addr <= dir_rd_addr_d;
            out_valid   <= out_valid_d;
            out_op      <= out_op_d;
            out_len     <= out_len_d;
            out_last    <= out_last_d;
            busy        <= busy_d;
            done        <= done_d;
            overrun     <= overrun_d;
        end
    end

    // Next-state, run accumulation and record formation
    always_comb begin
        state_d    = state_q;
        ret_d      = ret_q;
        pend_d     = pend_q;
        steps_d    = steps_q;
        total_d    = total_q;
        word_d     = word_q;
        lane_d     = lane_q;
        step_d     = step_q;
        run_op_d   = run_op_q;
        run_len_d  = run_len_q;
        word_buf_d = word_buf_q;
        out_op_d   = out_op;
        out_len_d  = out_len;
        out_last_d = out_last;
        overrun_d  = overrun;

        lane_word    = word_buf_q >> {lane_q, 1'b0};
        lane_op      = lane_word[1:0];
        step_inc     = step_q + STEP_W'(1);
        last_step    = (step_inc == steps_q);
        lane_end     = (lane_q == LANE_LAST);
        word_inc     = {1'b0, word_q} + AW1'(1);
        // Finishing the last stored word with steps still owed is an overrun
        out_of_words = lane_end && (word_inc == {1'b0, total_q});
        stop_now     = last_step || out_of_words;
        extend       = (run_len_q == '0) || (lane_op == run_op_q);
        cont_state   = lane_end ? S_FETCH : S_UNPACK;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    steps_d   = num_tb_steps;
                    total_d   = dir_total_count;
                    word_d    = '0;
                    lane_d    = '0;
                    step_d    = '0;
                    run_op_d  = '0;
                    run_len_d = '0;
                    pend_d    = 1'b0;
                    overrun_d = 1'b0;
                    if (num_tb_steps == '0) begin
                        state_d = S_DONE;
                    end else if (dir_total_count == '0) begin
                        // Nothing stored at all: no record, just flag it
                        overrun_d = 1'b1;
                        state_d   = S_DONE;
                    end else begin
                        state_d = S_FETCH;
                    end
                end
            end
            S_FETCH: state_d = S_WAIT;
            S_WAIT: begin
                word_buf_d = dir_data_out;
                state_d    = S_UNPACK;
            end
            S_UNPACK: begin
                step_d    = step_inc;
                run_op_d  = lane_op;
                run_len_d = extend ? run_len_q + STEP_W'(1) : STEP_W'(1);
                if (!last_step && out_of_words) overrun_d = 1'b1;
                if (lane_end) begin
                    lane_d = '0;
                    if (!stop_now) word_d = word_q + AW'(1);
                end else begin
                    lane_d = lane_q + LANE_W'(1);
                end
                if (!extend) begin
                    // Emit the finished run; if this lane also ends the tile,
                    // its fresh length-1 run follows as the final record
                    out_op_d   = run_op_q;
                    out_len_d  = run_len_q;
                    out_last_d = 1'b0;
                    pend_d     = stop_now;
                    ret_d      = cont_state;
                    state_d    = S_EMIT;
                end else if (stop_now) begin
                    out_op_d   = lane_op;
                    out_len_d  = run_len_d;
                    out_last_d = 1'b1;
                    state_d    = S_EMIT;
                end else begin
                    state_d = cont_state;
                end
            end
            S_EMIT: begin
                if (out_ready) begin
                    if (out_last) begin
                        state_d = S_DONE;
                    end else if (pend_q) begin
                        out_op_d   = run_op_q;
                        out_len_d  = run_len_q;
                        out_last_d = 1'b1;
                        pend_d     = 1'b0;
                    end else begin
                        state_d = ret_q;
                    end
                end
            end
            S_DONE: begin
                if (clear_done) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        dir_rd_addr_d = word_d;
        out_valid_d   = (state_d == S_EMIT);
        busy_d        = (state_d != S_IDLE);
        done_d        = (state_d == S_DONE);
    end

endmodule

// File: tb/tb_gactx_dir_reader.sv
// Scoreboard bench for gactx_dir_reader: directed tiles push expected run
// records into a queue; an independent monitor pops and compares on each
// accepted record.
module tb_gactx_dir_reader;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [21:0] num_tb_steps;
    logic [13:0] dir_total_count;
    logic [13:0] dir_rd_addr;
    logic [63:0] dir_data_out;
    logic        out_valid;
    logic        out_ready;
    logic [1:0]  out_op;
    logic [21:0] out_len;
    logic        out_last;
    logic        busy;
    logic        done;
    logic        overrun;
    logic        clear_done;

    typedef struct packed {
        logic [1:0]  op;
        logic [21:0] len;
        logic        last;
    } rec_t;

    rec_t        exp_q[$];
    int          total = 0;
    int          bad   = 0;
    logic [63:0] mem [0:15];
    bit          rand_ready = 1'b0;
    logic        ready_val  = 1'b1;

    gactx_dir_reader dut (
        .clk(clk), .rst(rst), .start(start), .num_tb_steps(num_tb_steps),
        .dir_total_count(dir_total_count), .dir_rd_addr(dir_rd_addr),
        .dir_data_out(dir_data_out), .out_valid(out_valid), .out_ready(out_ready),
        .out_op(out_op), .out_len(out_len), .out_last(out_last), .busy(busy),
        .done(done), .overrun(overrun), .clear_done(clear_done)
    );

    always #5 clk = ~clk;

    // One-cycle-latency BRAM model
    always @(posedge clk) dir_data_out <= mem[dir_rd_addr[3:0]];

    // Downstream ready driver
    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk); #1;
            out_ready = rand_ready ? 1'($urandom_range(0, 1)) : ready_val;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // Monitor: compare every accepted record against the scoreboard head
    initial begin : monitor
        rec_t e;
        forever begin
            @(negedge clk);
            if (rst !== 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_record: got op=%0d len=%0d last=%0d want none",
                             out_op, out_len, out_last);
                end else begin
                    e = exp_q.pop_front();
                    chk("rec_op",   32'(out_op),   32'(e.op));
                    chk("rec_len",  32'(out_len),  32'(e.len));
                    chk("rec_last", 32'(out_last), 32'(e.last));
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic push(input logic [1:0] op, input logic [21:0] len, input logic last);
        exp_q.push_back('{op: op, len: len, last: last});
    endtask

    task automatic run_tile(input string name, input logic [13:0] tot,
                            input logic [21:0] steps, input logic exp_ovr);
        int n;
        dir_total_count = tot;
        num_tb_steps    = steps;
        start = 1'b1;
        tick();
        start = 1'b0;
        n = 0;
        while (done !== 1'b1 && n < 2000) begin
            tick();
            n++;
        end
        chk({name, "_done"},    32'(done),         32'd1);
        chk({name, "_overrun"}, 32'(overrun),      32'(exp_ovr));
        chk({name, "_pending"}, 32'(exp_q.size()), 32'd0);
        exp_q.delete();
        clear_done = 1'b1;
        tick();
        clear_done = 1'b0;
        chk({name, "_idle"}, 32'(busy), 32'd0);
    endtask

    initial begin
        int n;
        rst = 1'b1; start = 1'b0; clear_done = 1'b0;
        num_tb_steps = '0; dir_total_count = '0;
        for (int i = 0; i < 16; i++) mem[i] = '0;
        repeat (3) tick();
        chk("rst_valid",   32'(out_valid),   32'd0);
        chk("rst_busy",    32'(busy),        32'd0);
        chk("rst_done",    32'(done),        32'd0);
        chk("rst_overrun", 32'(overrun),     32'd0);
        chk("rst_addr",    32'(dir_rd_addr), 32'd0);
        rst = 1'b0;
        tick();

        // Single word, single run
        mem[0] = {32{2'b01}};
        push(2'd1, 22'd32, 1'b1);
        run_tile("t1", 14'd1, 22'd32, 1'b0);

        // Run merges across the word boundary; tail lanes ignored
        mem[0] = {32{2'b10}};
        mem[1] = {32{2'b10}};
        push(2'd2, 22'd40, 1'b1);
        run_tile("t2", 14'd2, 22'd40, 1'b0);

        // Alternating ops: closing lane is also the last step
        mem[0] = {16{4'b1100}};
        push(2'd0, 22'd1, 1'b0);
        push(2'd3, 22'd1, 1'b0);
        push(2'd0, 22'd1, 1'b0);
        push(2'd3, 22'd1, 1'b1);
        run_tile("t3", 14'd1, 22'd4, 1'b0);

        // Zero steps: done the next cycle, no records
        dir_total_count = 14'd1;
        num_tb_steps    = 22'd0;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("t4_done",    32'(done),      32'd1);
        chk("t4_valid",   32'(out_valid), 32'd0);
        chk("t4_overrun", 32'(overrun),   32'd0);
        clear_done = 1'b1;
        tick();
        clear_done = 1'b0;

        // Overrun: steps exceed stored directions
        mem[0] = {32{2'b01}};
        push(2'd1, 22'd32, 1'b1);
        run_tile("t5", 14'd1, 22'd50, 1'b0 | 1'b1);

        // Op change just after the word boundary, with random backpressure
        mem[0] = {32{2'b01}};
        mem[1] = {{30{2'b11}}, {2{2'b01}}};
        rand_ready = 1'b1;
        push(2'd1, 22'd34, 1'b0);
        push(2'd3, 22'd30, 1'b1);
        run_tile("t7", 14'd2, 22'd64, 1'b0);
        rand_ready = 1'b0;
        ready_val  = 1'b1;
        repeat (2) tick();

        // Stall mid-tile, then reset
        mem[0] = {{28{2'b01}}, {4{2'b10}}};
        ready_val = 1'b0;
        repeat (2) tick();
        dir_total_count = 14'd1;
        num_tb_steps    = 22'd32;
        start = 1'b1;
        tick();
        start = 1'b0;
        n = 0;
        while (out_valid !== 1'b1 && n < 100) begin
            tick();
            n++;
        end
        chk("t6_valid_seen", 32'(out_valid), 32'd1);
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("t6_stall_valid", 32'(out_valid), 32'd1);
            chk("t6_stall_op",    32'(out_op),    32'd2);
            chk("t6_stall_len",   32'(out_len),   32'd4);
            chk("t6_stall_last",  32'(out_last),  32'd0);
        end
        rst = 1'b1;
        ready_val = 1'b1;
        tick();
        chk("t6_rst_valid", 32'(out_valid), 32'd0);
        chk("t6_rst_len",   32'(out_len),   32'd0);
        chk("t6_rst_busy",  32'(busy),      32'd0);
        tick();
        rst = 1'b0;
        exp_q.delete();
        repeat (2) tick();
        chk("t6_post_valid", 32'(out_valid), 32'd0);

        // Fresh tile after reset
        push(2'd2, 22'd4, 1'b0);
        push(2'd1, 22'd28, 1'b1);
        run_tile("t6b", 14'd1, 22'd32, 1'b0);

        repeat (3) tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
